// File: rtl/sfp_pkg.sv
// Shared operation and activation encodings for the special function processor.
package sfp_pkg;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ACC  = 2'b01;
  localparam logic [1:0] OP_ACT  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  localparam logic ACT_RELU  = 1'b0;
  localparam logic ACT_LEAKY = 1'b1;

endpackage

// File: rtl/sfp_lane.sv
// Combinational single-lane datapath: passthrough, accumulate, (leaky) ReLU or read-out.
module sfp_lane
  import sfp_pkg::*;
#(
  parameter int unsigned psum_bw    = 16,
  parameter int unsigned leak_shift = 6,
  parameter bit          sat        = 1'b1
) (
  input  logic [1:0]         op_i,
  input  logic               act_sel_i,
  input  logic [psum_bw-1:0] psum_i,
  input  logic [psum_bw-1:0] ofifo_i,
  output logic [psum_bw-1:0] res_o
);

  localparam logic [psum_bw-1:0] MaxVal = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] MinVal = {1'b1, {(psum_bw-1){1'b0}}};

  logic [psum_bw-1:0]        sum;
  logic                      ovf;
  logic signed [psum_bw-1:0] leaky;

  assign sum   = psum_i + ofifo_i;
  // Overflow only when both operands share a sign and the result flips it.
  assign ovf   = (psum_i[psum_bw-1] == ofifo_i[psum_bw-1]) &&
                 (sum[psum_bw-1] != psum_i[psum_bw-1]);
  assign leaky = $signed(psum_i) >>> leak_shift;

  always_comb begin
    res_o = ofifo_i;
    unique case (op_i)
      OP_PASS: res_o = ofifo_i;
      OP_ACC: begin
        if (sat && ovf) begin
          res_o = psum_i[psum_bw-1] ? MinVal : MaxVal;
        end else begin
          res_o = sum;
        end
      end
      OP_ACT: begin
        if (!psum_i[psum_bw-1]) begin
          res_o = psum_i;
        end else if (act_sel_i == ACT_LEAKY) begin
          res_o = leaky;
        end else begin
          res_o = '0;
        end
      end
      OP_READ: res_o = psum_i;
      default: res_o = ofifo_i;
    endcase
  end

endmodule

// File: rtl/sfp_array.sv
// Multi-lane special function processor: 2-stage valid/ready pipeline with address
// carried alongside each beat and a completed-vector counter.
module sfp_array
  import sfp_pkg::*;
#(
  parameter int unsigned col        = 8,
  parameter int unsigned psum_bw    = 16,
  parameter int unsigned addr_bw    = 11,
  parameter int unsigned leak_shift = 6,
  parameter bit          sat        = 1'b1,
  parameter int unsigned cnt_bw     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             op,
  input  logic                   act_sel,
  input  logic [addr_bw-1:0]     in_addr,
  input  logic [col*psum_bw-1:0] psum_in,
  input  logic [col*psum_bw-1:0] ofifo_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [col*psum_bw-1:0] sfp_out,
  output logic [addr_bw-1:0]     out_addr,
  output logic                   out_wr,
  input  logic                   clr_cnt,
  output logic [cnt_bw-1:0]      vec_cnt
);

  localparam int unsigned W = col * psum_bw;

  logic               s1_valid_q, s1_valid_d;
  logic [1:0]         s1_op_q, s1_op_d;
  logic               s1_act_q, s1_act_d;
  logic [addr_bw-1:0] s1_addr_q, s1_addr_d;
  logic [W-1:0]       s1_psum_q, s1_psum_d;
  logic [W-1:0]       s1_ofifo_q, s1_ofifo_d;

  logic               s2_valid_q, s2_valid_d;
  logic [W-1:0]       s2_data_q, s2_data_d;
  logic [addr_bw-1:0] s2_addr_q, s2_addr_d;
  logic               s2_wr_q, s2_wr_d;

  logic [cnt_bw-1:0]  cnt_q, cnt_d;

  logic               s1_adv, s2_adv;
  logic [W-1:0]       lane_res;

  for (genvar i = 0; i < int'(col); i++) begin : g_lane
    sfp_lane #(
      .psum_bw   (psum_bw),
      .leak_shift(leak_shift),
      .sat       (sat)
    ) u_lane (
      .op_i     (s1_op_q),
      .act_sel_i(s1_act_q),
      .psum_i   (s1_psum_q[i*psum_bw +: psum_bw]),
      .ofifo_i  (s1_ofifo_q[i*psum_bw +: psum_bw]),
      .res_o    (lane_res[i*psum_bw +: psum_bw])
    );
  end

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_act_d   = s1_act_q;
    s1_addr_d  = s1_addr_q;
    s1_psum_d  = s1_psum_q;
    s1_ofifo_d = s1_ofifo_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_addr_d  = s2_addr_q;
    s2_wr_d    = s2_wr_q;
    cnt_d      = cnt_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d    = op;
        s1_act_d   = act_sel;
        s1_addr_d  = in_addr;
        s1_psum_d  = psum_in;
        s1_ofifo_d = ofifo_in;
      end
    end

    // Result registers only move on a real beat so a stalled output stays put.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = lane_res;
        s2_addr_d = s1_addr_q;
        s2_wr_d   = (s1_op_q != OP_READ);
      end
    end

    if (clr_cnt) begin
      cnt_d = '0;
    end else if (s2_valid_q && out_ready) begin
      cnt_d = cnt_q + cnt_bw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_PASS;
      s1_act_q   <= ACT_RELU;
      s1_addr_q  <= '0;
      s1_psum_q  <= '0;
      s1_ofifo_q <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_addr_q  <= '0;
      s2_wr_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_act_q   <= s1_act_d;
      s1_addr_q  <= s1_addr_d;
      s1_psum_q  <= s1_psum_d;
      s1_ofifo_q <= s1_ofifo_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_addr_q  <= s2_addr_d;
      s2_wr_q    <= s2_wr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign sfp_out   = s2_data_q;
  assign out_addr  = s2_addr_q;
  assign out_wr    = s2_wr_q;
  assign vec_cnt   = cnt_q;

endmodule

// File: tb/tb_sfp_array.sv
// Scoreboard bench for sfp_array: driver pushes model results, monitor pops on handshakes.
module tb_sfp_array;
  import sfp_pkg::*;

  localparam int COL = 2;
  localparam int PW  = 16;
  localparam int AW  = 11;
  localparam int CW  = 16;
  localparam int W   = COL * PW;

  typedef struct {
    logic [W-1:0]  data;
    logic [AW-1:0] addr;
    logic          wr;
  } exp_t;

  logic          clk, reset, in_valid, in_ready, act_sel, out_valid, out_ready, out_wr, clr_cnt;
  logic [1:0]    op;
  logic [AW-1:0] in_addr, out_addr;
  logic [W-1:0]  psum_in, ofifo_in, sfp_out;
  logic [CW-1:0] vec_cnt;
  logic          ns_in_ready, ns_out_valid, ns_out_wr;
  logic [AW-1:0] ns_out_addr;
  logic [W-1:0]  ns_sfp_out;
  logic [CW-1:0] ns_vec_cnt;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  logic [CW-1:0] model_cnt = '0;
  logic          prev_stall = 1'b0;
  logic [W-1:0]  prev_data;
  logic [AW-1:0] prev_addr;
  logic          prev_wr;
  logic          rnd_on = 1'b0;

  sfp_array #(
    .col(COL), .psum_bw(PW), .addr_bw(AW), .leak_shift(6), .sat(1'b1), .cnt_bw(CW)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .act_sel(act_sel), .in_addr(in_addr), .psum_in(psum_in), .ofifo_in(ofifo_in),
    .out_valid(out_valid), .out_ready(out_ready), .sfp_out(sfp_out), .out_addr(out_addr),
    .out_wr(out_wr), .clr_cnt(clr_cnt), .vec_cnt(vec_cnt)
  );

  sfp_array #(
    .col(COL), .psum_bw(PW), .addr_bw(AW), .leak_shift(6), .sat(1'b0), .cnt_bw(CW)
  ) dut_ns (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ns_in_ready), .op(op),
    .act_sel(act_sel), .in_addr(in_addr), .psum_in(psum_in), .ofifo_in(ofifo_in),
    .out_valid(ns_out_valid), .out_ready(out_ready), .sfp_out(ns_sfp_out),
    .out_addr(ns_out_addr), .out_wr(ns_out_wr), .clr_cnt(clr_cnt), .vec_cnt(ns_vec_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference lane computed with integer arithmetic on signed values.
  function automatic logic [PW-1:0] ref_lane(input logic [1:0] o, input logic a,
                                             input logic [PW-1:0] p, input logic [PW-1:0] f,
                                             input bit s);
    int pi, fi, r;
    pi = int'($signed(p));
    fi = int'($signed(f));
    case (o)
      2'b00: r = fi;
      2'b01: begin
        r = pi + fi;
        if (s && r > 32767) r = 32767;
        if (s && r < -32768) r = -32768;
      end
      2'b10: begin
        if (pi >= 0) r = pi;
        else if (a) r = -((-pi + 63) / 64);
        else r = 0;
      end
      default: r = pi;
    endcase
    return r[PW-1:0];
  endfunction

  // Called at #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [1:0] o, input logic a, input logic [AW-1:0] ad,
                      input logic [W-1:0] p, input logic [W-1:0] f);
    exp_t e;
    int   n;
    bit   ok;
    op = o; act_sel = a; in_addr = ad; psum_in = p; ofifo_in = f; in_valid = 1'b1;
    for (int i = 0; i < COL; i++) e.data[i*PW +: PW] = ref_lane(o, a, p[i*PW +: PW],
                                                                f[i*PW +: PW], 1'b1);
    e.addr = ad;
    e.wr   = (o != OP_READ);
    n = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else n++;
    end
    if (ok) exp_q.push_back(e);
    else chk("send_timeout", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) chk(name, 64'(out_valid), 64'(1));
  endtask

  // Monitor: scoreboard pops, stall stability and counter model.
  initial forever begin
    @(negedge clk);
    chk("vec_cnt", 64'(vec_cnt), 64'(model_cnt));
    if (!reset) begin
      prev_stall = 1'b0;
      model_cnt  = '0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_data", 64'(sfp_out), 64'(prev_data));
        chk("stall_addr", 64'(out_addr), 64'(prev_addr));
        chk("stall_wr", 64'(out_wr), 64'(prev_wr));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'(out_valid), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", 64'(sfp_out), 64'(mon_e.data));
          chk("out_addr", 64'(out_addr), 64'(mon_e.addr));
          chk("out_wr", 64'(out_wr), 64'(mon_e.wr));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = sfp_out;
      prev_addr  = out_addr;
      prev_wr    = out_wr;
      if (clr_cnt) model_cnt = '0;
      else if (out_valid && out_ready) model_cnt = model_cnt + 1'b1;
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; op = OP_PASS; act_sel = 1'b0; in_addr = '0;
    psum_in = '0; ofifo_in = '0; out_ready = 1'b1; clr_cnt = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_sfp_out", 64'(sfp_out), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    // Saturating accumulate and latency
    send(OP_ACC, 1'b0, 11'h010, {16'hFFFB, 16'h7FF0}, {16'h0003, 16'h0020});
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_lat1", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("t1_lat2", 64'(out_valid), 64'(1));
    chk("t1_lane0", 64'(sfp_out[15:0]), 64'(16'h7FFF));
    chk("t1_lane1", 64'(sfp_out[31:16]), 64'(16'hFFFE));
    chk("t1_wr", 64'(out_wr), 64'(1));
    @(posedge clk);
    #1;

    // Activations
    send(OP_ACT, ACT_LEAKY, 11'h020, {16'hFFFF, 16'hFF80}, $urandom);
    send(OP_ACT, ACT_RELU, 11'h021, {16'h0100, 16'hFF80}, $urandom);
    send(OP_ACT, ACT_LEAKY, 11'h022, {16'hFF80, 16'h0100}, $urandom);
    in_valid = 1'b0;
    drain();

    // Backpressure on a six-beat stream
    clr_cnt = 1'b1;
    @(posedge clk);
    #1 clr_cnt = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(OP_PASS, 1'b0, AW'(i), $urandom, $urandom);
        in_valid = 1'b0;
      end
      begin
        wait_out_valid("t3_first_out");
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("t3_in_ready_stall", 64'(in_ready), 64'(0));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("t3_vec_cnt", 64'(vec_cnt), 64'(6));

    // Read-out
    send(OP_READ, 1'b0, 11'h5A5, {16'h8001, 16'h1234}, {16'hFFFF, 16'hFFFF});
    in_valid = 1'b0;
    drain();

    // Randomised traffic with random backpressure
    rnd_on = 1'b1;
    fork
      while (rnd_on) begin
        @(posedge clk);
        #1 out_ready = ($urandom % 4) != 0;
      end
    join_none
    for (int i = 0; i < 150; i++) begin
      if ($urandom % 5 == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send(2'($urandom), 1'($urandom), AW'($urandom), $urandom, $urandom);
    end
    in_valid = 1'b0;
    rnd_on = 1'b0;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Reset with both stages full and output stalled
    out_ready = 1'b0;
    send(OP_PASS, 1'b0, 11'h100, $urandom, $urandom);
    send(OP_PASS, 1'b0, 11'h101, $urandom, $urandom);
    in_valid = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("t5_out_valid", 64'(out_valid), 64'(0));
    chk("t5_sfp_out", 64'(sfp_out), 64'(0));
    chk("t5_vec_cnt", 64'(vec_cnt), 64'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    send(OP_ACC, 1'b0, 11'h102, {16'h0002, 16'h0005}, {16'h0003, 16'hFFFF});
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_lat1", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("t5_lat2", 64'(out_valid), 64'(1));
    chk("t5_addr", 64'(out_addr), 64'(11'h102));
    @(posedge clk);
    #1;

    // Wrapping accumulate on the non-saturating instance, clear during a handshake
    send(OP_ACC, 1'b0, 11'h007, {16'h0000, 16'h7FFF}, {16'h0000, 16'h0001});
    in_valid = 1'b0;
    wait_out_valid("t6_out_valid");
    clr_cnt = 1'b1;
    chk("t6_ns_valid", 64'(ns_out_valid), 64'(1));
    chk("t6_nosat", 64'(ns_sfp_out[15:0]), 64'(16'h8000));
    @(posedge clk);
    #1 clr_cnt = 1'b0;
    @(negedge clk);
    chk("t6_clr", 64'(vec_cnt), 64'(0));
    @(posedge clk);
    #1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
